frame_scheduler: RTL and testbench
==================================

# frame_scheduler

Parametrised raster scheduler for the ray-marching video path. Generates screen coordinates for a fixed-latency, non-stallable ray/shading pipeline. Issues a coordinate only when a slot is reserved in its output FIFO, so backpressure never loses pixels. Drains results in order onto an AXI4-Stream video port with start-of-frame on tuser and end-of-line on tlast.

## Interface
- H_RES, 640: active pixels per line (≥2)
- V_RES, 480: lines per frame (≥2)
- FIFO_DEPTH, 64: output FIFO entries, which is also the maximum in-flight pixels (power of 2, ≥4)
- COLOR_WIDTH, 8: bits per colour channel (1..8)
- XW, $clog2(H_RES) and YW, $clog2(V_RES): derived localparams
- out_stream_aclk  in  1  sole clock
- periph_resetn  in  1  asynchronous, active-low reset
- enable  in  1  run frames while high
- coord_x  out  XW  pixel column to ray pipeline
- coord_y  out  YW  pixel row to ray pipeline
- coord_valid  out  1  one-cycle issue strobe
- pix_valid  in  1  pipeline result strobe, in issue order
- pix_rgb  in  3*COLOR_WIDTH  {r,g,b}
- out_stream_tdata  out  32  {8'h00, r8, g8, b8}
- out_stream_tkeep  out  4  constant 4'hF
- out_stream_tlast  out  1  last pixel of line
- out_stream_tuser  out  1  first pixel of frame
- out_stream_tvalid  out  1
- out_stream_tready  in  1
- frame_count  out  16  completed output frames, wraps
- busy  out  1  state != IDLE
- overflow_err  out  1  sticky, set on unexpected pix_valid

## Operation
- Counters:
  - Issue side: ix/iy.
  - Output side: ox/oy.
  - inflight: issued minus returned.
  - fifo_cnt.
- Issue condition: RUN and (inflight + fifo_cnt) < FIFO_DEPTH.
- States:
  - IDLE: coord_valid=0. enable=1 → RUN with ix=iy=0.
  - RUN: issue in raster order, x fastest. ix wraps at H_RES-1, iy wraps at V_RES-1. On the issue of pixel (H_RES-1, V_RES-1): enable=1 → stay in RUN at (0,0); enable=0 → DRAIN. enable is ignored mid-frame, so a frame is never truncated.
  - DRAIN: no issue. inflight==0 and fifo_cnt==0 → IDLE.
- pix_valid with inflight==0: drop the data and set overflow_err. Only reset clears overflow_err.
- Channel packing: each channel is MSB-aligned into its byte, low bits zero.
- Stream flags:
  - tuser=1 iff ox==0 and oy==0.
  - tlast=1 iff ox==H_RES-1.
  - Both come from the output counters, which advance only on tvalid&tready.
  - frame_count increments on the beat where ox==H_RES-1 and oy==V_RES-1.
- Simultaneous events:
  - Issue and pix_valid in the same cycle: inflight unchanged.
  - pix_valid push and stream pop in the same cycle: fifo_cnt unchanged.
  - Issue and pop in the same cycle: total occupancy unchanged.

## Timing
- Reset (async assert, sync deassert assumed upstream) values:
  - Outputs: coord_valid=0, coord_x=coord_y=0, out_stream_tvalid=0, tlast=0, tuser=0, tdata=0, frame_count=0, busy=0, overflow_err=0.
  - Internal: all counters 0, state IDLE.
- Reset mid-frame discards all FIFO contents and in-flight accounting.
- coord_x/y/valid are registered. The first issue occurs 1 cycle after enable is sampled high in IDLE.
- Throughput is one issue per cycle while credits remain.
- FIFO is show-ahead. A pixel pushed into an empty FIFO at edge t appears on tvalid after edge t+1, so input-to-output latency is 1 cycle. tdata, tlast and tuser are stable while tvalid=1 and tready=0.
- tvalid never drops without a handshake, except on reset.

## Configuration
- FRAME_SCHED_PATTERN_EN defined:
  - Adds input pattern_sel (1 bit).
  - While pattern_sel=1, tdata = {8'h00, ox[7:0], oy[7:0], frame_count[7:0]}. tlast, tuser, flow control and FIFO pop are unchanged.
- Undefined: the pattern_sel port and its logic are absent, and tdata is always FIFO data.

## Test plan
All scenarios use H_RES=4, V_RES=2, FIFO_DEPTH=4 and a pipeline model with fixed latency 5.
1. Basic frame: enable=1, tready=1.
   - Coords issue in raster order (0,0)…(3,1).
   - 8 beats out; tuser on beat 0; tlast on beats 3 and 7.
   - frame_count=1 after beat 7.
2. Backpressure: tready=0 from reset, enable=1.
   - Exactly 4 coord_valid strobes, then none.
   - Raise tready: remaining pixels flow with data order intact, and no beat changes while stalled.
3. Enable drop: lower enable after the 3rd issue.
   - Remaining 5 pixels still issued; busy falls after beat 7.
   - frame_count=1, no 9th issue.
4. Spurious result: pix_valid=1 while inflight=0.
   - overflow_err=1 next cycle and stays 1; fifo_cnt unchanged.
5. Mid-frame reset: assert periph_resetn=0 with 3 pixels buffered and tready=0.
   - tvalid=0 and coord_valid=0 immediately.
   - After release with enable=1, the next beat carries tuser=1.
6. FRAME_SCHED_PATTERN_EN with pattern_sel=1, second frame: beat (2,1) tdata=32'h00020101.

Source files
------------

// File: rtl/frame_scheduler.sv
// frame_scheduler: raster coordinate generator for the ray-marching video path.
// Coordinates are issued only when a slot in the output FIFO is reserved for the
// result, so a non-stallable fixed-latency pipeline can never overrun the FIFO.
// Results drain in order onto an AXI4-Stream video port (tuser = SOF, tlast = EOL).
// Optional feature: define FRAME_SCHED_PATTERN_EN to add the pattern_sel input,
// which replaces tdata with a counter-based test pattern.
module frame_scheduler #(
    parameter  int H_RES       = 640,
    parameter  int V_RES       = 480,
    parameter  int FIFO_DEPTH  = 64,
    parameter  int COLOR_WIDTH = 8,
    localparam int XW          = $clog2(H_RES),
    localparam int YW          = $clog2(V_RES)
) (
    input  logic                     out_stream_aclk,
    input  logic                     periph_resetn,
    input  logic                     enable,
`ifdef FRAME_SCHED_PATTERN_EN
    input  logic                     pattern_sel,
`endif
    output logic [XW-1:0]            coord_x,
    output logic [YW-1:0]            coord_y,
    output logic                     coord_valid,
    input  logic                     pix_valid,
    input  logic [3*COLOR_WIDTH-1:0] pix_rgb,
    output logic [31:0]              out_stream_tdata,
    output logic [3:0]               out_stream_tkeep,
    output logic                     out_stream_tlast,
    output logic                     out_stream_tuser,
    output logic                     out_stream_tvalid,
    input  logic                     out_stream_tready,
    output logic [15:0]              frame_count,
    output logic                     busy,
    output logic                     overflow_err
);

    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CW   = PW + 1;
    localparam int RGBW = 3 * COLOR_WIDTH;

    localparam logic [XW-1:0] X_LAST    = XW'(H_RES - 1);
    localparam logic [YW-1:0] Y_LAST    = YW'(V_RES - 1);
    localparam logic [CW:0]   OCC_LIMIT = (CW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t          state;
    logic [XW-1:0]   ix, ox;
    logic [YW-1:0]   iy, oy;
    logic [CW-1:0]   inflight;
    logic [CW-1:0]   mem_cnt;
    logic [CW-1:0]   fifo_cnt;
    logic [CW:0]     occupancy;
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [RGBW-1:0] mem [FIFO_DEPTH];
    logic            out_valid;
    logic [23:0]     out_rgb;
    logic            issue;
    logic            accept;
    logic            load;
    logic            pop_out;

    // Expands each channel into its byte, MSB-aligned with zero low bits.
    function automatic logic [23:0] pack_rgb(input logic [RGBW-1:0] p);
        logic [7:0] r, g, b;
        r = 8'(p[3*COLOR_WIDTH-1 -: COLOR_WIDTH]) << (8 - COLOR_WIDTH);
        g = 8'(p[2*COLOR_WIDTH-1 -: COLOR_WIDTH]) << (8 - COLOR_WIDTH);
        b = 8'(p[COLOR_WIDTH-1 -: COLOR_WIDTH])   << (8 - COLOR_WIDTH);
        return {r, g, b};
    endfunction

    // The output register counts as a FIFO slot so credits cover every buffered pixel.
    assign fifo_cnt  = mem_cnt + CW'(out_valid);
    assign occupancy = {1'b0, inflight} + {1'b0, fifo_cnt};
    assign issue     = (state == RUN) && (occupancy < OCC_LIMIT);
    assign accept    = pix_valid && (inflight != '0);
    assign pop_out   = out_valid && out_stream_tready;
    assign load      = (mem_cnt != '0) && (!out_valid || out_stream_tready);

    // Frame sequencer: raster walk of the issue counters and registered coordinate outputs.
    always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
        if (!periph_resetn) begin
            state       <= IDLE;
            ix          <= '0;
            iy          <= '0;
            coord_x     <= '0;
            coord_y     <= '0;
            coord_valid <= 1'b0;
        end else begin
            coord_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable) begin
                        state <= RUN;
                        ix    <= '0;
                        iy    <= '0;
                    end
                end
                RUN: begin
                    if (issue) begin
                        coord_valid <= 1'b1;
                        coord_x     <= ix;
                        coord_y     <= iy;
                        if (ix == X_LAST) begin
                            ix <= '0;
                            if (iy == Y_LAST) begin
                                iy <= '0;
                                if (!enable) state <= DRAIN;
                            end else begin
                                iy <= iy + 1'b1;
                            end
                        end else begin
                            ix <= ix + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (inflight == '0 && fifo_cnt == '0) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tracks pixels issued to the ray pipeline whose results have not come back yet.
    always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
        if (!periph_resetn) begin
            inflight <= '0;
        end else begin
            case ({issue, accept})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase
        end
    end

    // FIFO storage; contents are only meaningful where the counters say so, so no reset.
    always_ff @(posedge out_stream_aclk) begin
        if (accept) mem[wr_ptr] <= pix_rgb;
    end

    // FIFO pointers plus the show-ahead output register feeding the stream.
    always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
        if (!periph_resetn) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            mem_cnt   <= '0;
            out_valid <= 1'b0;
            out_rgb   <= '0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + 1'b1;
            if (load) begin
                rd_ptr    <= rd_ptr + 1'b1;
                out_rgb   <= pack_rgb(mem[rd_ptr]);
                out_valid <= 1'b1;
            end else if (pop_out) begin
                out_valid <= 1'b0;
            end
            case ({accept, load})
                2'b10:   mem_cnt <= mem_cnt + 1'b1;
                2'b01:   mem_cnt <= mem_cnt - 1'b1;
                default: mem_cnt <= mem_cnt;
            endcase
        end
    end

    // Output raster position and completed-frame count, advanced per stream handshake.
    always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
        if (!periph_resetn) begin
            ox          <= '0;
            oy          <= '0;
            frame_count <= '0;
        end else if (pop_out) begin
            if (ox == X_LAST) begin
                ox <= '0;
                if (oy == Y_LAST) begin
                    oy          <= '0;
                    frame_count <= frame_count + 16'd1;
                end else begin
                    oy <= oy + 1'b1;
                end
            end else begin
                ox <= ox + 1'b1;
            end
        end
    end

    // Sticky flag for a pipeline result that arrives with nothing in flight.
    always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
        if (!periph_resetn) begin
            overflow_err <= 1'b0;
        end else if (pix_valid && inflight == '0) begin
            overflow_err <= 1'b1;
        end
    end

    assign out_stream_tvalid = out_valid;
    assign out_stream_tkeep  = 4'hF;
    assign out_stream_tuser  = out_valid && (ox == '0) && (oy == '0);
    assign out_stream_tlast  = out_valid && (ox == X_LAST);
    assign busy              = (state != IDLE);

`ifdef FRAME_SCHED_PATTERN_EN
    logic [7:0] ox8, oy8;
    assign ox8 = 8'(ox);
    assign oy8 = 8'(oy);
    assign out_stream_tdata = pattern_sel ? {8'h00, ox8, oy8, frame_count[7:0]}
                                          : {8'h00, out_rgb};
`else
    assign out_stream_tdata = {8'h00, out_rgb};
`endif

endmodule

// File: tb/tb_frame_scheduler.sv
// tb_frame_scheduler: directed bench for frame_scheduler with a 4x2 raster,
// 4-entry FIFO and a fixed-latency-5 pipeline model returning {0x10+x, 0x20+y, 0xA0+seq}.
`timescale 1ns/1ps
module tb_frame_scheduler;

    localparam int H = 4;
    localparam int V = 2;
    localparam int D = 4;
    localparam int C = 8;

    logic        clk = 1'b0;
    logic        rstn;
    logic        enable;
    logic [1:0]  coord_x;
    logic [0:0]  coord_y;
    logic        coord_valid;
    logic        pix_valid;
    logic [23:0] pix_rgb;
    logic [31:0] tdata;
    logic [3:0]  tkeep;
    logic        tlast;
    logic        tuser;
    logic        tvalid;
    logic        tready;
    logic [15:0] frame_count;
    logic        busy;
    logic        overflow_err;
`ifdef FRAME_SCHED_PATTERN_EN
    logic        pattern_sel;
`endif

    logic        pv [5];
    logic [23:0] pd [5];
    logic [7:0]  seq;
    logic        spur;

    logic [31:0] b_data [64];
    logic        b_last [64];
    logic        b_user [64];
    logic [1:0]  i_x [64];
    logic [0:0]  i_y [64];
    int          beats;
    int          issues;
    int          rets;
    int          checks;
    int          errors;

    frame_scheduler #(
        .H_RES(H), .V_RES(V), .FIFO_DEPTH(D), .COLOR_WIDTH(C)
    ) dut (
        .out_stream_aclk  (clk),
        .periph_resetn    (rstn),
        .enable           (enable),
`ifdef FRAME_SCHED_PATTERN_EN
        .pattern_sel      (pattern_sel),
`endif
        .coord_x          (coord_x),
        .coord_y          (coord_y),
        .coord_valid      (coord_valid),
        .pix_valid        (pix_valid),
        .pix_rgb          (pix_rgb),
        .out_stream_tdata (tdata),
        .out_stream_tkeep (tkeep),
        .out_stream_tlast (tlast),
        .out_stream_tuser (tuser),
        .out_stream_tvalid(tvalid),
        .out_stream_tready(tready),
        .frame_count      (frame_count),
        .busy             (busy),
        .overflow_err     (overflow_err)
    );

    always #5 clk = ~clk;

    // Ray pipeline model: five register stages, result tagged with coords and issue order.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 5; i++) begin
                pv[i] <= 1'b0;
                pd[i] <= '0;
            end
            seq <= '0;
        end else begin
            pv[0] <= coord_valid;
            pd[0] <= {8'h10 + {6'b0, coord_x}, 8'h20 + {7'b0, coord_y}, 8'hA0 + seq};
            if (coord_valid) seq <= seq + 8'd1;
            for (int i = 1; i < 5; i++) begin
                pv[i] <= pv[i-1];
                pd[i] <= pd[i-1];
            end
        end
    end

    assign pix_valid = pv[4] | spur;
    assign pix_rgb   = pd[4];

    function automatic logic [31:0] exp_pix(input int k);
        logic [7:0] x8, y8, s8;
        x8 = 8'(k % H);
        y8 = 8'((k / H) % V);
        s8 = 8'(k);
        return {8'h00, 8'h10 + x8, 8'h20 + y8, 8'hA0 + s8};
    endfunction

    task automatic clear_logs();
        beats  = 0;
        issues = 0;
        rets   = 0;
    endtask

    // One clock: log what the coming edge will do, then move to the next negedge.
    task automatic cycle();
        if (coord_valid) begin
            if (issues < 64) begin
                i_x[issues] = coord_x;
                i_y[issues] = coord_y;
            end
            issues++;
        end
        if (tvalid && tready) begin
            if (beats < 64) begin
                b_data[beats] = tdata;
                b_last[beats] = tlast;
                b_user[beats] = tuser;
            end
            beats++;
        end
        if (pix_valid) rets++;
        @(negedge clk);
    endtask

    task automatic do_reset(input logic rdy);
        rstn   = 1'b0;
        enable = 1'b0;
        tready = rdy;
        spur   = 1'b0;
        repeat (2) @(negedge clk);
        clear_logs();
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        rstn   = 1'b0;
        enable = 1'b0;
        tready = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (coord_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_coord_valid got %h exp 0", coord_valid); end
        checks++; if (coord_x !== 2'd0) begin errors++; $display("[TB] FAIL rst_coord_x got %h exp 0", coord_x); end
        checks++; if (coord_y !== 1'd0) begin errors++; $display("[TB] FAIL rst_coord_y got %h exp 0", coord_y); end
        checks++; if (tvalid !== 1'b0) begin errors++; $display("[TB] FAIL rst_tvalid got %h exp 0", tvalid); end
        checks++; if (tlast !== 1'b0) begin errors++; $display("[TB] FAIL rst_tlast got %h exp 0", tlast); end
        checks++; if (tuser !== 1'b0) begin errors++; $display("[TB] FAIL rst_tuser got %h exp 0", tuser); end
        checks++; if (tdata !== 32'h0) begin errors++; $display("[TB] FAIL rst_tdata got %h exp 0", tdata); end
        checks++; if (tkeep !== 4'hF) begin errors++; $display("[TB] FAIL rst_tkeep got %h exp f", tkeep); end
        checks++; if (frame_count !== 16'd0) begin errors++; $display("[TB] FAIL rst_frame_count got %h exp 0", frame_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy got %h exp 0", busy); end
        checks++; if (overflow_err !== 1'b0) begin errors++; $display("[TB] FAIL rst_overflow got %h exp 0", overflow_err); end
        clear_logs();
        rstn = 1'b1;
    endtask

    task automatic test_basic_frame();
        int budget;
        do_reset(1'b1);
        enable = 1'b1;
        budget = 300;
        while (beats < 8 && budget > 0) begin cycle(); budget--; end
        checks++; if (beats < 8) begin errors++; $display("[TB] FAIL basic_timeout got %0d beats exp 8", beats); end
        checks++; if (frame_count !== 16'd1) begin errors++; $display("[TB] FAIL basic_frame_count got %0d exp 1", frame_count); end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (i_x[k] !== 2'(k % H) || i_y[k] !== 1'(k / H)) begin
                errors++; $display("[TB] FAIL basic_issue%0d got (%0d,%0d) exp (%0d,%0d)", k, i_x[k], i_y[k], k % H, k / H);
            end
            checks++;
            if ({b_user[k], b_last[k], b_data[k]} !== {(k == 0), (k % H == H - 1), exp_pix(k)}) begin
                errors++; $display("[TB] FAIL basic_beat%0d got u%0d l%0d %h exp u%0d l%0d %h", k, b_user[k], b_last[k], b_data[k], (k == 0), (k % H == H - 1), exp_pix(k));
            end
        end
        // Frame two runs back to back; enable is dropped mid-frame and only takes effect at its end.
        enable = 1'b0;
        budget = 300;
        while ((beats < 16 || busy) && budget > 0) begin cycle(); budget--; end
        checks++; if (budget == 0) begin errors++; $display("[TB] FAIL b2b_timeout got %0d beats exp 16", beats); end
        checks++; if (frame_count !== 16'd2) begin errors++; $display("[TB] FAIL b2b_frame_count got %0d exp 2", frame_count); end
        checks++; if (issues !== 16) begin errors++; $display("[TB] FAIL b2b_issues got %0d exp 16", issues); end
        checks++;
        if ({b_user[8], b_last[8], b_data[8]} !== {1'b1, 1'b0, exp_pix(8)}) begin
            errors++; $display("[TB] FAIL b2b_beat8 got u%0d l%0d %h exp u1 l0 %h", b_user[8], b_last[8], b_data[8], exp_pix(8));
        end
        checks++;
        if ({b_user[15], b_last[15], b_data[15]} !== {1'b0, 1'b1, exp_pix(15)}) begin
            errors++; $display("[TB] FAIL b2b_beat15 got u%0d l%0d %h exp u0 l1 %h", b_user[15], b_last[15], b_data[15], exp_pix(15));
        end
    endtask

    task automatic test_backpressure();
        int budget;
        do_reset(1'b0);
        enable = 1'b1;
        cycle();
        enable = 1'b0;
        repeat (30) cycle();
        checks++; if (issues !== D) begin errors++; $display("[TB] FAIL bp_issues_stalled got %0d exp %0d", issues, D); end
        checks++; if (tvalid !== 1'b1) begin errors++; $display("[TB] FAIL bp_tvalid_stalled got %0d exp 1", tvalid); end
        for (int n = 0; n < 3; n++) begin
            checks++;
            if ({tuser, tlast, tdata} !== {1'b1, 1'b0, exp_pix(0)}) begin
                errors++; $display("[TB] FAIL bp_hold%0d got u%0d l%0d %h exp u1 l0 %h", n, tuser, tlast, tdata, exp_pix(0));
            end
            cycle();
        end
        tready = 1'b1;
        budget = 300;
        while ((beats < 8 || busy) && budget > 0) begin cycle(); budget--; end
        checks++; if (beats !== 8) begin errors++; $display("[TB] FAIL bp_beats got %0d exp 8", beats); end
        checks++; if (issues !== 8) begin errors++; $display("[TB] FAIL bp_issues got %0d exp 8", issues); end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if ({b_user[k], b_last[k], b_data[k]} !== {(k == 0), (k % H == H - 1), exp_pix(k)}) begin
                errors++; $display("[TB] FAIL bp_beat%0d got u%0d l%0d %h exp u%0d l%0d %h", k, b_user[k], b_last[k], b_data[k], (k == 0), (k % H == H - 1), exp_pix(k));
            end
        end
    endtask

    task automatic test_enable_drop();
        int budget;
        do_reset(1'b1);
        enable = 1'b1;
        budget = 100;
        while (issues < 3 && budget > 0) begin cycle(); budget--; end
        enable = 1'b0;
        budget = 300;
        while (beats < 8 && budget > 0) begin cycle(); budget--; end
        checks++; if (beats < 8) begin errors++; $display("[TB] FAIL drop_timeout got %0d beats exp 8", beats); end
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL drop_busy_last_beat got %0d exp 1", busy); end
        cycle();
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL drop_busy_after got %0d exp 0", busy); end
        repeat (20) cycle();
        checks++; if (issues !== 8) begin errors++; $display("[TB] FAIL drop_issues got %0d exp 8", issues); end
        checks++; if (frame_count !== 16'd1) begin errors++; $display("[TB] FAIL drop_frame_count got %0d exp 1", frame_count); end
        checks++;
        if ({b_last[7], b_data[7]} !== {1'b1, exp_pix(7)}) begin
            errors++; $display("[TB] FAIL drop_beat7 got l%0d %h exp l1 %h", b_last[7], b_data[7], exp_pix(7));
        end
    endtask

    task automatic test_spurious();
        do_reset(1'b1);
        repeat (2) cycle();
        checks++; if (overflow_err !== 1'b0) begin errors++; $display("[TB] FAIL spur_before got %0d exp 0", overflow_err); end
        spur = 1'b1;
        cycle();
        spur = 1'b0;
        checks++; if (overflow_err !== 1'b1) begin errors++; $display("[TB] FAIL spur_set got %0d exp 1", overflow_err); end
        repeat (5) cycle();
        checks++; if (overflow_err !== 1'b1) begin errors++; $display("[TB] FAIL spur_sticky got %0d exp 1", overflow_err); end
        checks++; if (tvalid !== 1'b0) begin errors++; $display("[TB] FAIL spur_tvalid got %0d exp 0", tvalid); end
        checks++; if (beats !== 0) begin errors++; $display("[TB] FAIL spur_beats got %0d exp 0", beats); end
    endtask

    task automatic test_midframe_reset();
        int budget;
        do_reset(1'b0);
        enable = 1'b1;
        budget = 100;
        while (rets < 3 && budget > 0) begin cycle(); budget--; end
        checks++; if (rets < 3) begin errors++; $display("[TB] FAIL mid_timeout got %0d returns exp 3", rets); end
        checks++; if (tvalid !== 1'b1) begin errors++; $display("[TB] FAIL mid_tvalid_pre got %0d exp 1", tvalid); end
        #2 rstn = 1'b0;
        #1;
        checks++; if (tvalid !== 1'b0) begin errors++; $display("[TB] FAIL mid_tvalid_rst got %0d exp 0", tvalid); end
        checks++; if (coord_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_coord_valid_rst got %0d exp 0", coord_valid); end
        @(negedge clk);
        clear_logs();
        rstn   = 1'b1;
        tready = 1'b1;
        budget = 100;
        while (beats < 1 && budget > 0) begin cycle(); budget--; end
        checks++;
        if ({b_user[0], b_data[0]} !== {1'b1, exp_pix(0)}) begin
            errors++; $display("[TB] FAIL mid_first_beat got u%0d %h exp u1 %h", b_user[0], b_data[0], exp_pix(0));
        end
        checks++; if (overflow_err !== 1'b0) begin errors++; $display("[TB] FAIL mid_overflow got %0d exp 0", overflow_err); end
        enable = 1'b0;
    endtask

`ifdef FRAME_SCHED_PATTERN_EN
    task automatic test_pattern();
        int budget;
        do_reset(1'b1);
        pattern_sel = 1'b1;
        enable      = 1'b1;
        budget      = 400;
        while (beats < 15 && budget > 0) begin
            if (beats >= 8) enable = 1'b0;
            cycle();
            budget--;
        end
        checks++; if (b_data[0] !== 32'h00000000) begin errors++; $display("[TB] FAIL pat_beat0 got %h exp 00000000", b_data[0]); end
        checks++; if (b_data[11] !== 32'h00030001) begin errors++; $display("[TB] FAIL pat_beat11 got %h exp 00030001", b_data[11]); end
        checks++; if (b_data[14] !== 32'h00020101) begin errors++; $display("[TB] FAIL pat_beat14 got %h exp 00020101", b_data[14]); end
        pattern_sel = 1'b0;
    endtask
`endif

    // Test sequence.
    initial begin
        rstn   = 1'b0;
        enable = 1'b0;
        tready = 1'b0;
        spur   = 1'b0;
        checks = 0;
        errors = 0;
`ifdef FRAME_SCHED_PATTERN_EN
        pattern_sel = 1'b0;
`endif
        clear_logs();
        @(negedge clk);
        test_reset();
        test_basic_frame();
        test_backpressure();
        test_enable_drop();
        test_spurious();
        test_midframe_reset();
`ifdef FRAME_SCHED_PATTERN_EN
        test_pattern();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
